// File: rtl/helix_efferent.sv
// Issue side of the efference/world/feedback loop: forks each command into an efference copy
// and a corrected world action, tracks in-flight credits and folds feedback deltas into a correction.
module helix_efferent #(
  parameter int THOUGHT_W  = 16,
  parameter int ACTION_W   = 8,
  parameter int FEEDBACK_W = 8,
  parameter int MAX_OUTST  = 4,
  parameter int CNT_W      = 8,
  parameter int CORRECT_EN = 1,
  localparam int OUT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [THOUGHT_W-1:0]  i_cmd_data,
  output logic                  o_efference_valid,
  input  logic                  i_efference_ready,
  output logic [THOUGHT_W-1:0]  o_efference_data,
  output logic                  o_world_valid,
  input  logic                  i_world_ready,
  output logic [ACTION_W-1:0]   o_world_data,
  input  logic                  i_feedback_valid,
  output logic                  o_feedback_ready,
  input  logic [FEEDBACK_W-1:0] i_feedback_delta,
  output logic [OUT_W-1:0]      o_outstanding,
  output logic [CNT_W-1:0]      o_mismatch_cnt,
  output logic                  o_underflow
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_run;
  logic                  r_eff_vld;
  logic                  r_wld_vld;
  logic [THOUGHT_W-1:0]  r_eff_data;
  logic [ACTION_W-1:0]   r_wld_data;
  logic [FEEDBACK_W-1:0] r_corr;
  logic [OUT_W-1:0]      r_outst;
  logic [CNT_W-1:0]      r_mcnt;
  logic                  r_underflow;

  logic w_cmd_hs;
  logic w_fb_hs;
  logic w_eff_hs;
  logic w_wld_hs;
  logic w_dec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ACTION_W-1:0] correct_action(input logic [THOUGHT_W-1:0] cmd,
                                                        input logic [FEEDBACK_W-1:0] corr);
    return cmd[ACTION_W-1:0] ^ corr[ACTION_W-1:0];
  endfunction

  assign w_cmd_hs = i_cmd_valid & o_cmd_ready;
  assign w_fb_hs  = i_feedback_valid & r_run;
  assign w_eff_hs = r_eff_vld & i_efference_ready;
  assign w_wld_hs = r_wld_vld & i_world_ready;
  assign w_dec    = w_fb_hs & (r_outst != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
    end
  end

  // cmd_ready derives only from registered state, so a same-cycle feedback cannot raise it
  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = r_run & (r_outst < OUT_W'(MAX_OUTST));
        if (w_cmd_hs) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if ((!r_eff_vld || w_eff_hs) && (!r_wld_vld || w_wld_hs)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output channels: both launched together, each retired by its own handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eff_vld  <= 1'b0;
      r_wld_vld  <= 1'b0;
      r_eff_data <= '0;
      r_wld_data <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_eff_vld  <= 1'b1;
        r_wld_vld  <= 1'b1;
        r_eff_data <= i_cmd_data;
        r_wld_data <= correct_action(i_cmd_data, r_corr);
      end else begin
        if (w_eff_hs) r_eff_vld <= 1'b0;
        if (w_wld_hs) r_wld_vld <= 1'b0;
      end
    end
  end

  // Credit and feedback bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outst     <= '0;
      r_corr      <= '0;
      r_mcnt      <= '0;
      r_underflow <= 1'b0;
    end else begin
      case ({w_cmd_hs, w_dec})
        2'b10:   r_outst <= r_outst + OUT_W'(1);
        2'b01:   r_outst <= r_outst - OUT_W'(1);
        default: r_outst <= r_outst;
      endcase
      if (w_fb_hs) begin
        if (r_outst == '0) r_underflow <= 1'b1;
        if (CORRECT_EN != 0) r_corr <= i_feedback_delta;
        if (i_feedback_delta != '0) r_mcnt <= sat_inc(r_mcnt);
      end
    end
  end

  assign o_efference_valid = r_eff_vld;
  assign o_efference_data  = r_eff_data;
  assign o_world_valid     = r_wld_vld;
  assign o_world_data      = r_wld_data;
  assign o_feedback_ready  = r_run;
  assign o_outstanding     = r_outst;
  assign o_mismatch_cnt    = r_mcnt;
  assign o_underflow       = r_underflow;

endmodule

// File: tb/tb_helix_efferent.sv
// Directed bench for helix_efferent: command fork, correction, credits, underflow, async reset.
module tb_helix_efferent;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic        eff_valid;
  logic        eff_ready = 1'b1;
  logic [15:0] eff_data;
  logic        wld_valid;
  logic        wld_ready = 1'b1;
  logic [7:0]  wld_data;
  logic        fb_valid = 1'b0;
  logic        fb_ready;
  logic [7:0]  fb_delta = '0;
  logic [2:0]  outstanding;
  logic [7:0]  mcnt;
  logic        underflow;

  int n_tests = 0;
  int n_fail  = 0;

  helix_efferent #(
    .THOUGHT_W(16), .ACTION_W(8), .FEEDBACK_W(8), .MAX_OUTST(4), .CNT_W(8), .CORRECT_EN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_data(cmd_data),
    .o_efference_valid(eff_valid), .i_efference_ready(eff_ready), .o_efference_data(eff_data),
    .o_world_valid(wld_valid), .i_world_ready(wld_ready), .o_world_data(wld_data),
    .i_feedback_valid(fb_valid), .o_feedback_ready(fb_ready), .i_feedback_delta(fb_delta),
    .o_outstanding(outstanding), .o_mismatch_cnt(mcnt), .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command and hold it until the handshake edge; leaves us #1 after that edge
  task automatic send_cmd(input logic [15:0] d, input logic with_fb, input logic [7:0] delta);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        if (with_fb) begin
          fb_valid = 1'b1;
          fb_delta = delta;
        end
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    cmd_valid = 1'b0;
    fb_valid  = 1'b0;
    if (!ok) check("cmd_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_fb(input logic [7:0] delta);
    fb_valid = 1'b1;
    fb_delta = delta;
    step();
    fb_valid = 1'b0;
  endtask

  int eff_hs;

  initial begin
    // Reset state
    step(); step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_fb_ready", 32'(fb_ready), 32'd0);
    check("rst_valids", 32'({eff_valid, wld_valid}), 32'd0);
    check("rst_outst", 32'(outstanding), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("run_fb_ready", 32'(fb_ready), 32'd1);

    // 1: plain command fork
    send_cmd(16'h12A5, 1'b0, 8'h00);
    check("t1_eff_valid", 32'(eff_valid), 32'd1);
    check("t1_wld_valid", 32'(wld_valid), 32'd1);
    check("t1_eff_data", 32'(eff_data), 32'h12A5);
    check("t1_wld_data", 32'(wld_data), 32'hA5);
    check("t1_outst", 32'(outstanding), 32'd1);
    check("t1_issue_ready", 32'(cmd_ready), 32'd0);
    step();
    check("t1_valids_drop", 32'({eff_valid, wld_valid}), 32'd0);
    check("t1_idle_ready", 32'(cmd_ready), 32'd1);

    // 2: correction from feedback
    send_fb(8'h0F);
    check("t2_mcnt", 32'(mcnt), 32'd1);
    check("t2_outst", 32'(outstanding), 32'd0);
    send_cmd(16'h0033, 1'b0, 8'h00);
    check("t2_eff_data", 32'(eff_data), 32'h0033);
    check("t2_wld_data", 32'(wld_data), 32'h3C);
    step();
    send_fb(8'h00);
    check("t2_mcnt_zero_delta", 32'(mcnt), 32'd1);
    check("t2_outst_after", 32'(outstanding), 32'd0);

    // 3: world stalled, efference completes alone
    wld_ready = 1'b0;
    eff_hs = 0;
    send_cmd(16'h00A5, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (eff_valid && eff_ready) eff_hs++;
      check("t3_wld_valid", 32'(wld_valid), 32'd1);
      check("t3_wld_data", 32'(wld_data), 32'hA5);
      check("t3_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    check("t3_eff_hs", 32'(eff_hs), 32'd1);
    wld_ready = 1'b1;
    step();
    check("t3_wld_drop", 32'(wld_valid), 32'd0);
    check("t3_idle_ready", 32'(cmd_ready), 32'd1);
    send_fb(8'h00);

    // 4: credit limit
    for (int i = 0; i < 4; i++) begin
      send_cmd(16'(16'h0100 + i), 1'b0, 8'h00);
      step();
    end
    check("t4_outst_full", 32'(outstanding), 32'd4);
    check("t4_ready_full", 32'(cmd_ready), 32'd0);
    fb_valid = 1'b1;
    fb_delta = 8'h00;
    @(negedge clk);
    check("t4_ready_same_cycle", 32'(cmd_ready), 32'd0);
    step();
    fb_valid = 1'b0;
    check("t4_outst_3", 32'(outstanding), 32'd3);
    check("t4_ready_next", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) send_fb(8'h00);
    check("t4_outst_drained", 32'(outstanding), 32'd0);

    // 5: underflow, then simultaneous command and feedback
    check("t5_no_underflow", 32'(underflow), 32'd0);
    send_fb(8'h55);
    check("t5_underflow", 32'(underflow), 32'd1);
    check("t5_outst_zero", 32'(outstanding), 32'd0);
    check("t5_mcnt", 32'(mcnt), 32'd2);
    step();
    check("t5_underflow_sticky", 32'(underflow), 32'd1);
    send_cmd(16'h0011, 1'b0, 8'h00);
    check("t5_wld_corr55", 32'(wld_data), 32'h44);
    step();
    send_cmd(16'h0022, 1'b1, 8'hF0);
    check("t5_outst_net", 32'(outstanding), 32'd1);
    check("t5_old_corr", 32'(wld_data), 32'h77);
    check("t5_mcnt3", 32'(mcnt), 32'd3);
    step();
    send_cmd(16'h0022, 1'b0, 8'h00);
    check("t5_new_corr", 32'(wld_data), 32'hD2);
    check("t5_outst2", 32'(outstanding), 32'd2);

    // 6: async reset mid-transfer
    wld_ready = 1'b0;
    step();
    check("t6_pending_wld", 32'(wld_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_valids", 32'({eff_valid, wld_valid}), 32'd0);
    check("t6_outst", 32'(outstanding), 32'd0);
    check("t6_corr", 32'(dut.r_corr), 32'd0);
    check("t6_mcnt", 32'(mcnt), 32'd0);
    check("t6_underflow", 32'(underflow), 32'd0);
    check("t6_fb_ready", 32'(fb_ready), 32'd0);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wld_ready = 1'b1;
    step();
    send_cmd(16'h00A5, 1'b0, 8'h00);
    check("t6_wld_uncorrected", 32'(wld_data), 32'hA5);
    step();

    // mismatch counter saturation
    fb_valid = 1'b1;
    fb_delta = 8'h01;
    for (int i = 0; i < 260; i++) step();
    fb_valid = 1'b0;
    check("sat_mcnt", 32'(mcnt), 32'hFF);
    check("sat_outst", 32'(outstanding), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
